// File: rtl/image_nav_buttons.sv
// image_nav_buttons: synchronise and debounce front-panel buttons, emit press/release/repeat pulses,
// and track the displayed image index with a one-cycle delete request.
module image_nav_buttons #(
    parameter int                 NUM_BTN         = 3,
    parameter int                 DEBOUNCE_CYCLES = 65536,
    parameter int                 HOLD_CYCLES     = 50000000,
    parameter int                 REPEAT_CYCLES   = 10000000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(3'b011),
    parameter int                 NUM_IMAGES      = 4,
    parameter int                 INDEX_W         = 2,
    parameter bit                 WRAP            = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat,
    output logic [INDEX_W-1:0] image_index,
    output logic               index_changed,
    output logic               delete_flag
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW = $clog2(HMAX);
    // Delete must never auto-repeat, whatever the mask says
    localparam logic [NUM_BTN-1:0] RMASK = REPEAT_MASK & ~(NUM_BTN'(3'b100));
    localparam logic [INDEX_W-1:0] LAST = INDEX_W'(NUM_IMAGES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [NUM_BTN-1:0] s0, s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= btn_raw;
            s1 <= s0;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [DW-1:0] dcnt;
        logic [HW-1:0] hcnt, hcnt_nxt;
        logic          lvl, prs, rls, rep, rep_nxt, accept, lvl_nxt;
        state_t        state, state_nxt;

        assign accept  = (s1[i] != lvl) && dcnt == DW'(DEBOUNCE_CYCLES - 1);
        assign lvl_nxt = accept ? s1[i] : lvl;

        assign btn_level[i]   = lvl;
        assign btn_press[i]   = prs;
        assign btn_release[i] = rls;
        assign btn_repeat[i]  = rep;

        always_ff @(posedge clk) begin
            if (reset) begin
                dcnt  <= '0;
                lvl   <= 1'b0;
                prs   <= 1'b0;
                rls   <= 1'b0;
                rep   <= 1'b0;
                state <= IDLE;
                hcnt  <= '0;
            end else begin
                dcnt  <= (s1[i] == lvl || accept) ? '0 : dcnt + 1'b1;
                lvl   <= lvl_nxt;
                prs   <= accept & s1[i];
                rls   <= accept & ~s1[i];
                rep   <= rep_nxt;
                state <= state_nxt;
                hcnt  <= hcnt_nxt;
            end
        end

        // The FSM looks at the next debounced level so repeat never coincides with release
        always_comb begin
            state_nxt = state;
            hcnt_nxt  = hcnt + 1'b1;
            rep_nxt   = 1'b0;
            case (state)
                IDLE: begin
                    hcnt_nxt = '0;
                    if (accept) state_nxt = HOLD;
                end
                HOLD: if (hcnt == HW'(HOLD_CYCLES - 1)) begin
                    rep_nxt   = 1'b1;
                    state_nxt = REPEAT;
                    hcnt_nxt  = '0;
                end
                REPEAT: if (hcnt == HW'(REPEAT_CYCLES - 1)) begin
                    rep_nxt  = 1'b1;
                    hcnt_nxt = '0;
                end
                default: state_nxt = IDLE;
            endcase
            if (!RMASK[i] || !lvl_nxt) begin
                state_nxt = IDLE;
                hcnt_nxt  = '0;
                rep_nxt   = 1'b0;
            end
        end
    end

    logic               up, dn;
    logic [INDEX_W-1:0] inc, dec, idx_nxt;

    assign up      = btn_press[1] | btn_repeat[1];
    assign dn      = btn_press[0] | btn_repeat[0];
    assign inc     = image_index == LAST ? (WRAP ? '0 : LAST) : image_index + 1'b1;
    assign dec     = image_index == '0 ? (WRAP ? LAST : '0) : image_index - 1'b1;
    assign idx_nxt = (up & ~dn) ? inc : (dn & ~up) ? dec : image_index;

    always_ff @(posedge clk) begin
        if (reset) begin
            image_index   <= '0;
            index_changed <= 1'b0;
            delete_flag   <= 1'b0;
        end else begin
            image_index   <= idx_nxt;
            index_changed <= idx_nxt != image_index;
            delete_flag   <= btn_press[2];
        end
    end
endmodule

// File: doc/image_nav_buttons.md
# image_nav_buttons

Parametrised front-panel input controller for the image viewer. It synchronises and debounces `NUM_BTN` raw push-buttons and emits per-button press, release and auto-repeat pulses. It also maintains the displayed image index from the left/right buttons, with wrap or saturate mode, and raises a one-cycle delete request. It sits between the board button pins and the image selection / frame-buffer control logic.

## Interface
Clocking: one clock; reset is synchronous and active-high (`clk`, `reset`).

Parameters:
- `NUM_BTN`, 3: button channels. Channels 0 = left, 1 = right and 2 = delete are required, so `NUM_BTN >= 3`. Higher channels are debounced only.
- `DEBOUNCE_CYCLES`, 65536: consecutive mismatching cycles needed to accept a level change. Must be `>= 2`.
- `HOLD_CYCLES`, 50000000: cycles from press to the first auto-repeat pulse.
- `REPEAT_CYCLES`, 10000000: cycles between subsequent auto-repeat pulses.
- `REPEAT_MASK`, `NUM_BTN'b011`: per-channel auto-repeat enable.
- `NUM_IMAGES`, 4: index range is 0..`NUM_IMAGES`-1. Must be `>= 2`.
- `INDEX_W`, 2: index width, with `2**INDEX_W >= NUM_IMAGES`.
- `WRAP`, 1: 1 = wrap-around, 0 = saturate at the ends.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `btn_raw` input `NUM_BTN`: asynchronous raw buttons, active-high.
- `btn_level` output `NUM_BTN`: debounced level.
- `btn_press` output `NUM_BTN`: one-cycle pulse on debounced 0→1.
- `btn_release` output `NUM_BTN`: one-cycle pulse on debounced 1→0.
- `btn_repeat` output `NUM_BTN`: one-cycle auto-repeat pulse.
- `image_index` output `INDEX_W`: current image.
- `index_changed` output 1: one-cycle pulse when `image_index` takes a new value.
- `delete_flag` output 1: one-cycle delete request.

## Operation
Per channel, the stages are: 2-FF synchroniser (`s0`, `s1`), then debouncer, then edge detect, then hold FSM.

Debouncer:
- If `s1 != btn_level`, the counter increments.
- If the counter is `DEBOUNCE_CYCLES-1` and still mismatching, `btn_level <= s1` and the counter clears.
- If `s1 == btn_level`, the counter clears. Glitches shorter than `DEBOUNCE_CYCLES` therefore have no effect.

Edges:
- `btn_press[i]` is high in exactly the first cycle `btn_level[i]` is 1.
- `btn_release[i]` is high in exactly the first cycle it is 0.

Hold FSM, per channel, only when `REPEAT_MASK[i]` is set. States are IDLE, HOLD and REPEAT.
- IDLE → HOLD on `btn_press`, with the counter cleared.
- In HOLD, `btn_repeat` pulses after `HOLD_CYCLES` cycles, then the FSM goes to REPEAT with the counter cleared.
- In REPEAT, `btn_repeat` pulses every `REPEAT_CYCLES` cycles.
- HOLD or REPEAT → IDLE as soon as `btn_level` is 0. No repeat pulse is issued in the release cycle.
- Masked channels stay in IDLE and `btn_repeat[i]` is always 0.

Step events: `up = press[1] | repeat[1]` and `dn = press[0] | repeat[0]`.
- `up & dn` together: no change. This is a defined cancel.
- `up` only: `WRAP=1` gives `(idx == NUM_IMAGES-1) ? 0 : idx+1`. `WRAP=0` holds at `NUM_IMAGES-1`.
- `dn` only: `WRAP=1` gives `(idx == 0) ? NUM_IMAGES-1 : idx-1`. `WRAP=0` holds at 0.
- `index_changed` pulses only if the stored value actually differs. It is never asserted on a saturated step or on a cancel.

`delete_flag` = `btn_press[2]`, registered. Delete is never auto-repeated, regardless of `REPEAT_MASK[2]`; it is forced off.

Reset: all synchronisers, counters, FSMs and outputs go to 0, and `image_index` goes to 0. A button held through reset is re-debounced and reported as a new press.

## Timing
- `btn_raw` rises before edge k and stays high: `btn_level` and `btn_press` are high after edge k+1+`DEBOUNCE_CYCLES`.
- Release has the same latency and produces `btn_release`.
- `image_index`, `index_changed` and `delete_flag` update one edge after the cycle in which `btn_press` or `btn_repeat` is high.
- First `btn_repeat` comes `HOLD_CYCLES` cycles after the `btn_press` cycle. Subsequent repeats are spaced `REPEAT_CYCLES` apart.
- `reset` is sampled on `clk`. All outputs are 0 in the cycle after `reset` is sampled high.
- A `reset` asserted mid-debounce or mid-hold discards the partial count.
- All outputs are registered.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=4`, `HOLD_CYCLES=8`, `REPEAT_CYCLES=3`, `NUM_IMAGES=5`, `INDEX_W=3`.

1. **Glitch:** pulse `btn_raw[1]` high for 3 cycles → no `btn_level`, no `btn_press`, and `image_index` stays 0.
2. **Wrap:** `WRAP=1`, 5 clean right presses → `image_index` 1,2,3,4,0 with 5 `index_changed` pulses. Then one left press → 4.
3. **Saturate:** `WRAP=0`, 6 right presses → `image_index` ends at 4. The 5th and 6th presses give no `index_changed`. Left at 0 → stays 0.
4. **Auto-repeat:** hold right for 20 cycles after `btn_press` → repeats at +8, +11, +14, +17 and `image_index` = 5 steps total. On release, `btn_release` pulses once.
5. **Cancel and delete:** left and right pressed in the same cycle → index unchanged, no `index_changed`. Delete held 30 cycles → exactly one `delete_flag` pulse.
6. **Reset mid-hold:** hold right, assert `reset` at cycle 10 → all outputs 0 next cycle. With the button still held, `btn_press` reappears 5 cycles after `reset` deasserts.
